// File: rtl/axi_lite_req_frontend.sv
// AXI4-Lite slave front end for the APB bridge core.
// Captures AW and W into holding registers, pairs them into one write request,
// arbitrates writes against reads round-robin, and presents one request at a
// time to the core. The core's completion pulse is returned on B or R.
//
// Handshake rule used on every channel: a transfer happens on the rising edge
// where valid && ready are both high. A valid, once raised by this block, stays
// high with stable payload until that edge. Ready may depend on valid
// combinationally (arready does), but valid never depends on ready.
module axi_lite_req_frontend #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // AXI write address
  input  logic                awvalid,
  output logic                awready,
  input  logic [ADDR_W-1:0]   awaddr,
  // AXI write data
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  // AXI write response
  output logic                bvalid,
  input  logic                bready,
  output logic [1:0]          bresp,
  // AXI read address
  input  logic                arvalid,
  output logic                arready,
  input  logic [ADDR_W-1:0]   araddr,
  // AXI read data
  output logic                rvalid,
  input  logic                rready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  // Request to bridge core
  output logic                req_valid,
  input  logic                req_ready,
  output logic                req_write,
  output logic [ADDR_W-1:0]   req_addr,
  output logic [DATA_W-1:0]   req_wdata,
  output logic [DATA_W/8-1:0] req_wstrb,
  // Completion from bridge core
  input  logic                rsp_valid,
  input  logic [DATA_W-1:0]   rsp_rdata,
  input  logic                rsp_err
);

  typedef enum logic [2:0] {
    F_IDLE  = 3'd0,
    F_REQ   = 3'd1,
    F_WAIT  = 3'd2,
    F_BRESP = 3'd3,
    F_RRESP = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  // Write holding registers
  logic                aw_full;
  logic                w_full;
  logic [ADDR_W-1:0]   aw_addr_q;
  logic [DATA_W-1:0]   w_data_q;
  logic [DATA_W/8-1:0] w_strb_q;

  // 1 = write wins the next tie, 0 = read wins the next tie
  logic prio_wr;

  logic wr_elig;
  logic rd_elig;
  logic grant_wr;
  logic grant_rd;
  logic aw_hs;
  logic w_hs;
  logic in_idle;

  assign in_idle = (state == F_IDLE);

  // Ready outputs are forced low while reset is held so the bus sees a quiet slave.
  assign awready = !rst && in_idle && !aw_full;
  assign wready  = !rst && in_idle && !w_full;
  assign arready = !rst && grant_rd;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  assign req_valid = (state == F_REQ);
  assign bvalid    = (state == F_BRESP);
  assign rvalid    = (state == F_RRESP);

  // Arbiter: a complete write pair competes against a pending AR, ties go to prio_wr.
  always_comb begin
    wr_elig  = aw_full && w_full;
    rd_elig  = arvalid;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (in_idle) begin
      grant_wr = wr_elig && (prio_wr || !rd_elig);
      grant_rd = rd_elig && (!prio_wr || !wr_elig);
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= F_IDLE;
    else     state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      F_IDLE:  if (grant_wr || grant_rd) state_next = F_REQ;
      F_REQ:   if (req_ready) state_next = F_WAIT;
      F_WAIT:  if (rsp_valid) state_next = req_write ? F_BRESP : F_RRESP;
      F_BRESP: if (bready) state_next = F_IDLE;
      F_RRESP: if (rready) state_next = F_IDLE;
      default: state_next = F_IDLE;
    endcase
  end

  // AW/W holding registers: each fills on its own handshake, both drain on a write grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else if (grant_wr) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_full   <= 1'b1;
        aw_addr_q <= awaddr;
      end
      if (w_hs) begin
        w_full   <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
    end
  end

  // Request fields latched at grant time and held until the core takes them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_write <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
      prio_wr   <= 1'b1;
    end else if (grant_wr) begin
      req_write <= 1'b1;
      req_addr  <= aw_addr_q;
      req_wdata <= w_data_q;
      req_wstrb <= w_strb_q;
      prio_wr   <= 1'b0;
    end else if (grant_rd) begin
      req_write <= 1'b0;
      req_addr  <= araddr;
      req_wdata <= '0;
      req_wstrb <= '0;
      prio_wr   <= 1'b1;
    end
  end

  // Completion capture: only a pulse seen in F_WAIT produces a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bresp <= 2'b00;
      rresp <= 2'b00;
      rdata <= '0;
    end else if (state == F_WAIT && rsp_valid) begin
      if (req_write) begin
        bresp <= rsp_err ? 2'b10 : 2'b00;
      end else begin
        rresp <= rsp_err ? 2'b10 : 2'b00;
        rdata <= rsp_rdata;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_req_frontend.sv
// Directed bench for axi_lite_req_frontend. The bench plays both the AXI
// master and the bridge core; expected values are written out by hand.
module tb_axi_lite_req_frontend;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic                clk;
  logic                rst;
  logic                awvalid;
  logic                awready;
  logic [ADDR_W-1:0]   awaddr;
  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                bvalid;
  logic                bready;
  logic [1:0]          bresp;
  logic                arvalid;
  logic                arready;
  logic [ADDR_W-1:0]   araddr;
  logic                rvalid;
  logic                rready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [DATA_W/8-1:0] req_wstrb;
  logic                rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;

  int n_cmp;
  int n_err;

  axi_lite_req_frontend #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .awvalid   (awvalid),
    .awready   (awready),
    .awaddr    (awaddr),
    .wvalid    (wvalid),
    .wready    (wready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .bvalid    (bvalid),
    .bready    (bready),
    .bresp     (bresp),
    .arvalid   (arvalid),
    .arready   (arready),
    .araddr    (araddr),
    .rvalid    (rvalid),
    .rready    (rready),
    .rdata     (rdata),
    .rresp     (rresp),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  // Single comparison point
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; registered outputs are settled 2 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Let combinational outputs follow newly driven inputs.
  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    awvalid = 1'b0; awaddr = '0;
    wvalid = 1'b0; wdata = '0; wstrb = '0;
    bready = 1'b0;
    arvalid = 1'b0; araddr = '0;
    rready = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0; rsp_rdata = '0; rsp_err = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Core side: stall req_ready, accept, then pulse the completion.
  task automatic core_complete(input int stall, input logic [DATA_W-1:0] rd, input logic err);
    repeat (stall) tick();
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    rsp_valid = 1'b1; rsp_rdata = rd; rsp_err = err;
    tick();
    rsp_valid = 1'b0; rsp_rdata = '0; rsp_err = 1'b0;
  endtask

  task automatic b_accept();
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic r_accept();
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clear_inputs();
    rst = 1'b1;

    // ---- Reset state, with master valids raised to expose ready gating
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    tick();
    settle();
    check_eq("rst_awready", awready, 0);
    check_eq("rst_wready", wready, 0);
    check_eq("rst_arready", arready, 0);
    check_eq("rst_req_valid", req_valid, 0);
    check_eq("rst_bvalid", bvalid, 0);
    check_eq("rst_rvalid", rvalid, 0);
    check_eq("rst_bresp", bresp, 0);
    check_eq("rst_rresp", rresp, 0);
    check_eq("rst_rdata", rdata, 0);
    do_reset();

    // ---- 1. AW at cycle 0, W at cycle 3, request at cycle 5
    awvalid = 1'b1; awaddr = 32'h10;
    settle();
    check_eq("t1_awready", awready, 1);
    tick();
    awvalid = 1'b0;
    settle();
    check_eq("t1_aw_held_awready", awready, 0);
    tick();
    tick();
    wvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    settle();
    check_eq("t1_wready", wready, 1);
    tick();
    wvalid = 1'b0;
    check_eq("t1_c4_req_valid", req_valid, 0);
    tick();
    check_eq("t1_c5_req_valid", req_valid, 1);
    check_eq("t1_req_write", req_write, 1);
    check_eq("t1_req_addr", req_addr, 32'h10);
    check_eq("t1_req_wdata", req_wdata, 32'hDEADBEEF);
    check_eq("t1_req_wstrb", req_wstrb, 4'hF);
    core_complete(0, 32'h0, 1'b0);
    check_eq("t1_bvalid", bvalid, 1);
    check_eq("t1_bresp", bresp, 2'b00);
    b_accept();
    check_eq("t1_bvalid_done", bvalid, 0);

    // ---- 2. Read with SLVERR
    arvalid = 1'b1; araddr = 32'h24;
    settle();
    check_eq("t2_arready", arready, 1);
    tick();
    arvalid = 1'b0;
    check_eq("t2_req_valid", req_valid, 1);
    check_eq("t2_req_write", req_write, 0);
    check_eq("t2_req_addr", req_addr, 32'h24);
    check_eq("t2_req_wstrb", req_wstrb, 0);
    core_complete(0, 32'h12345678, 1'b1);
    check_eq("t2_rvalid", rvalid, 1);
    check_eq("t2_rdata", rdata, 32'h12345678);
    check_eq("t2_rresp", rresp, 2'b10);
    r_accept();
    check_eq("t2_rvalid_done", rvalid, 0);

    // ---- 3. Contention: write wins first after reset, read wins the next tie
    do_reset();
    awvalid = 1'b1; awaddr = 32'h100; wvalid = 1'b1; wdata = 32'hA; wstrb = 4'hF;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    arvalid = 1'b1; araddr = 32'h200;
    settle();
    check_eq("t3a_arready", arready, 0);
    tick();
    // AR is withdrawn so the next tie is set up afresh rather than served alone
    arvalid = 1'b0;
    check_eq("t3a_req_write", req_write, 1);
    check_eq("t3a_req_addr", req_addr, 32'h100);
    core_complete(0, 32'h0, 1'b0);
    b_accept();

    awvalid = 1'b1; awaddr = 32'h104; wvalid = 1'b1; wdata = 32'hB; wstrb = 4'hF;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    arvalid = 1'b1; araddr = 32'h204;
    settle();
    check_eq("t3b_arready", arready, 1);
    tick();
    arvalid = 1'b0;
    check_eq("t3b_req_valid", req_valid, 1);
    check_eq("t3b_req_write", req_write, 0);
    check_eq("t3b_req_addr", req_addr, 32'h204);
    core_complete(0, 32'h55, 1'b0);
    check_eq("t3b_rdata", rdata, 32'h55);
    r_accept();
    tick();
    check_eq("t3c_req_valid", req_valid, 1);
    check_eq("t3c_req_write", req_write, 1);
    check_eq("t3c_req_addr", req_addr, 32'h104);
    check_eq("t3c_req_wdata", req_wdata, 32'hB);
    core_complete(0, 32'h0, 1'b0);
    b_accept();

    // ---- 4. Backpressure on req_ready and on bready
    awvalid = 1'b1; awaddr = 32'h300; wvalid = 1'b1; wdata = 32'hCAFEF00D; wstrb = 4'h3;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    awvalid = 1'b1; awaddr = 32'h999; arvalid = 1'b1; araddr = 32'h998;
    for (int i = 0; i < 5; i++) begin
      settle();
      check_eq("t4_req_valid_held", req_valid, 1);
      check_eq("t4_req_addr_held", req_addr, 32'h300);
      check_eq("t4_req_wdata_held", req_wdata, 32'hCAFEF00D);
      check_eq("t4_req_wstrb_held", req_wstrb, 4'h3);
      check_eq("t4_req_arready", arready, 0);
      check_eq("t4_req_awready", awready, 0);
      tick();
    end
    core_complete(0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      settle();
      check_eq("t4_bvalid_held", bvalid, 1);
      check_eq("t4_bresp_held", bresp, 2'b10);
      check_eq("t4_b_arready", arready, 0);
      check_eq("t4_b_awready", awready, 0);
      tick();
    end
    awvalid = 1'b0; arvalid = 1'b0;
    b_accept();
    check_eq("t4_bvalid_done", bvalid, 0);

    // ---- 5a. W two cycles before AW
    wvalid = 1'b1; wdata = 32'h11112222; wstrb = 4'h5;
    tick();
    wvalid = 1'b0;
    settle();
    check_eq("t5a_w_held_wready", wready, 0);
    tick();
    awvalid = 1'b1; awaddr = 32'h40;
    tick();
    awvalid = 1'b0;
    check_eq("t5a_c3_req_valid", req_valid, 0);
    tick();
    check_eq("t5a_req_valid", req_valid, 1);
    check_eq("t5a_req_addr", req_addr, 32'h40);
    check_eq("t5a_req_wdata", req_wdata, 32'h11112222);
    check_eq("t5a_req_wstrb", req_wstrb, 4'h5);
    core_complete(0, 32'h0, 1'b0);
    b_accept();
    tick();
    tick();
    check_eq("t5a_no_second_req", req_valid, 0);

    // ---- 5b. AW and W in the same cycle: best-case latency of two cycles
    awvalid = 1'b1; awaddr = 32'h44; wvalid = 1'b1; wdata = 32'h33334444; wstrb = 4'hC;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check_eq("t5b_c1_req_valid", req_valid, 0);
    tick();
    check_eq("t5b_req_valid", req_valid, 1);
    check_eq("t5b_req_addr", req_addr, 32'h44);
    check_eq("t5b_req_wdata", req_wdata, 32'h33334444);
    check_eq("t5b_req_wstrb", req_wstrb, 4'hC);
    core_complete(0, 32'h0, 1'b0);
    b_accept();
    tick();
    settle();
    check_eq("t5b_no_second_req", req_valid, 0);
    check_eq("t5b_holding_empty", awready, 1);

    // ---- 6. Reset while waiting for the core
    awvalid = 1'b1; awaddr = 32'h50; wvalid = 1'b1; wdata = 32'h77; wstrb = 4'hF;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    check_eq("t6_req_valid", req_valid, 1);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    check_eq("t6_wait_req_valid", req_valid, 0);
    rst = 1'b1;
    awvalid = 1'b1;
    settle();
    check_eq("t6_async_awready", awready, 0);
    tick();
    check_eq("t6_rst_req_valid", req_valid, 0);
    check_eq("t6_rst_bvalid", bvalid, 0);
    check_eq("t6_rst_rvalid", rvalid, 0);
    check_eq("t6_rst_req_addr", req_addr, 0);
    rst = 1'b0;
    awvalid = 1'b0;
    rsp_valid = 1'b1; rsp_rdata = 32'hBAD; rsp_err = 1'b1;
    tick();
    rsp_valid = 1'b0; rsp_rdata = '0; rsp_err = 1'b0;
    check_eq("t6_late_rsp_bvalid", bvalid, 0);
    check_eq("t6_late_rsp_rvalid", rvalid, 0);
    tick();
    settle();
    check_eq("t6_after_bvalid", bvalid, 0);
    check_eq("t6_after_rvalid", rvalid, 0);
    check_eq("t6_after_bresp", bresp, 0);
    check_eq("t6_after_req_valid", req_valid, 0);
    check_eq("t6_after_awready", awready, 1);
    check_eq("t6_after_wready", wready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
